mem_req_queue: RTL

//  In-order dual-lane load/store request queue directly upstream of memory_system.

---
 rtl/mem_req_queue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order dual-lane load/store queue feeding two cache ports, holding and replaying on a miss.
// Build option MEMQ_PERF_EN adds saturating counters perf_miss_cnt / perf_dual_cnt.
module mem_req_queue #(
  parameter int DEPTH    = 8,
  parameter int MISS_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid0,
  input  logic        in_we0,
  input  logic [31:0] in_addr0,
  input  logic [31:0] in_wdata0,
  input  logic [4:0]  in_rd0,
  input  logic        in_valid1,
  input  logic        in_we1,
  input  logic [31:0] in_addr1,
  input  logic [31:0] in_wdata1,
  input  logic [4:0]  in_rd1,
  output logic        in_ready,
  output logic        mem_re0,
  output logic        mem_we0,
  output logic [31:0] mem_addr0,
  output logic [31:0] mem_wdata0,
  input  logic [31:0] mem_rdata0,
  input  logic        mem_hit0,
  input  logic        mem_miss0,
  output logic        mem_re1,
  output logic        mem_we1,
  output logic [31:0] mem_addr1,
  output logic [31:0] mem_wdata1,
  input  logic [31:0] mem_rdata1,
  input  logic        mem_hit1,
  input  logic        mem_miss1,
  output logic        wb_valid0,
  output logic [4:0]  wb_rd0,
  output logic [31:0] wb_data0,
  output logic        wb_valid1,
  output logic [4:0]  wb_rd1,
  output logic [31:0] wb_data1,
  output logic        stall
`ifdef MEMQ_PERF_EN
  ,
  output logic [31:0] perf_miss_cnt,
  output logic [31:0] perf_dual_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_REPLAY = 2'd2;
  localparam logic [AW:0] C_RDY = (AW+1)'(DEPTH - 2);
  localparam logic [2:0] C_LAT = 3'(MISS_LAT - 1);
  logic [1:0]    r_state, w_state_nx;
  logic [2:0]    r_lat, w_lat_nx;
  logic [AW:0]   r_head, r_tail, w_count, w_count_nx;
  logic          r_we    [DEPTH];
  logic [31:0]   r_addr  [DEPTH];
  logic [31:0]   r_wdata [DEPTH];
  logic [4:0]    r_rd    [DEPTH];
  logic [AW-1:0] w_h0, w_h1, w_t0, w_t1;
  logic          w_acc0, w_acc1, w_iss, w_conf, w_dual, w_ret0, w_ret1;
  logic [1:0]    w_enq, w_deq;
  assign w_count    = r_tail - r_head;
  assign in_ready   = w_count <= C_RDY;
  assign w_h0       = r_head[AW-1:0];
  assign w_h1       = w_h0 + AW'(1);
  assign w_t0       = r_tail[AW-1:0];
  assign w_acc0     = in_ready && in_valid0;
  assign w_acc1     = in_ready && in_valid1;
  assign w_t1       = w_acc0 ? w_t0 + AW'(1) : w_t0;
  assign w_enq      = {1'b0, w_acc0} + {1'b0, w_acc1};
  assign w_iss      = r_state == S_ISSUE;
  // Same word with a store on either side must not share a cycle, so the younger op waits.
  assign w_conf     = (r_addr[w_h0][31:2] == r_addr[w_h1][31:2]) && (r_we[w_h0] || r_we[w_h1]);
  assign w_dual     = w_iss && (w_count > (AW+1)'(1)) && !w_conf;
  // A simultaneous hit+miss counts as a miss; head+1 may only retire behind the head.
  assign w_ret0     = w_iss && mem_hit0 && !mem_miss0;
  assign w_ret1     = w_ret0 && w_dual && mem_hit1 && !mem_miss1;
  assign w_deq      = {1'b0, w_ret0} + {1'b0, w_ret1};
  assign w_count_nx = w_count + (AW+1)'(w_enq) - (AW+1)'(w_deq);
  assign mem_re0    = w_iss && !r_we[w_h0];
  assign mem_we0    = w_iss && r_we[w_h0];
  assign mem_addr0  = w_iss ? r_addr[w_h0] : '0;
  assign mem_wdata0 = w_iss ? r_wdata[w_h0] : '0;
  assign mem_re1    = w_dual && !r_we[w_h1];
  assign mem_we1    = w_dual && r_we[w_h1];
  assign mem_addr1  = w_dual ? r_addr[w_h1] : '0;
  assign mem_wdata1 = w_dual ? r_wdata[w_h1] : '0;
  assign stall      = r_state == S_REPLAY;
  // Next state: replay lasts exactly MISS_LAT cycles, then the same head is re-presented.
  always_comb begin
    w_state_nx = S_IDLE;
    w_lat_nx   = '0;
    if (r_state == S_IDLE) w_state_nx = (w_enq != 2'd0) ? S_ISSUE : S_IDLE;
    else if (r_state == S_ISSUE) w_state_nx = mem_miss0 ? S_REPLAY : (w_count_nx == '0) ? S_IDLE : S_ISSUE;
    else if (r_state == S_REPLAY) begin
      w_state_nx = (r_lat == C_LAT) ? S_ISSUE : S_REPLAY;
      w_lat_nx   = (r_lat == C_LAT) ? 3'd0 : r_lat + 3'd1;
    end
  end
  // Pointers and FSM; reset discards every queued entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lat   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_lat   <= w_lat_nx;
      r_head  <= r_head + (AW+1)'(w_deq);
      r_tail  <= r_tail + (AW+1)'(w_enq);
    end
  end
  // Entry storage; lane0 lands at tail, lane1 behind it or alone at tail.
  always_ff @(posedge clk) begin
    if (w_acc0) begin
      r_we[w_t0]    <= in_we0;
      r_addr[w_t0]  <= in_addr0;
      r_wdata[w_t0] <= in_wdata0;
      r_rd[w_t0]    <= in_rd0;
    end
    if (w_acc1) begin
      r_we[w_t1]    <= in_we1;
      r_addr[w_t1]  <= in_addr1;
      r_wdata[w_t1] <= in_wdata1;
      r_rd[w_t1]    <= in_rd1;
    end
  end
  // One-cycle load writeback in lane order; retired stores stay silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid0 <= 1'b0;
      wb_rd0    <= '0;
      wb_data0  <= '0;
      wb_valid1 <= 1'b0;
      wb_rd1    <= '0;
      wb_data1  <= '0;
    end else begin
      wb_valid0 <= w_ret0 && !r_we[w_h0];
      wb_rd0    <= (w_ret0 && !r_we[w_h0]) ? r_rd[w_h0] : '0;
      wb_data0  <= (w_ret0 && !r_we[w_h0]) ? mem_rdata0 : '0;
      wb_valid1 <= w_ret1 && !r_we[w_h1];
      wb_rd1    <= (w_ret1 && !r_we[w_h1]) ? r_rd[w_h1] : '0;
      wb_data1  <= (w_ret1 && !r_we[w_h1]) ? mem_rdata1 : '0;
    end
  end
`ifdef MEMQ_PERF_EN
  // Saturating event counters: port0 misses and dual-retire cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_miss_cnt <= '0;
      perf_dual_cnt <= '0;
    end else begin
      if (w_iss && mem_miss0 && perf_miss_cnt != '1) perf_miss_cnt <= perf_miss_cnt + 32'd1;
      if (w_ret1 && perf_dual_cnt != '1) perf_dual_cnt <= perf_dual_cnt + 32'd1;
    end
  end
`endif
endmodule
